// File: rtl/fsk_utxd_1byte.sv
// One-byte UART transmitter with continuous-phase FSK (DDS sine) modulation.
// Optional `UTXD_PARITY_EN inserts an even-parity bit before the stop bit.
module fsk_utxd_1byte #(
  parameter int FD_DIV      = 1000,
  parameter int SMP_PER_BIT = 50,
  parameter int MARK_INC    = 2621,
  parameter int SPACE_INC   = 5243
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st,
  input  logic [7:0]  TX_dat,
  output logic [11:0] FSK_SH,
  output logic        TXD,
  output logic        en_tx_byte,
  output logic [3:0]  cb_tx_bit,
  output logic        ce_Fd,
  output logic        ce_bit,
  output logic        T_end
);

  localparam int FDW = (FD_DIV > 1) ? $clog2(FD_DIV) : 1;
  localparam int SBW = (SMP_PER_BIT > 1) ? $clog2(SMP_PER_BIT) : 1;

`ifdef UTXD_PARITY_EN
  localparam logic [3:0] LAST = 4'd10;
`else
  localparam logic [3:0] LAST = 4'd9;
`endif

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]     state;
  logic [FDW-1:0] cb_Fd;
  logic [SBW-1:0] cb_smp;
  logic [15:0]    phase;
  logic [7:0]     sreg;
`ifdef UTXD_PARITY_EN
  logic           par;
`endif
  logic           accept;

  // Quarter-wave table of round(2000*sin(2*pi*i/64)), i=0..16; the other
  // three quadrants are mirrored from it.
  function automatic logic [11:0] sin_lut(input logic [5:0] k);
    logic [4:0]  i;
    logic [10:0] off;
    i = k[4] ? (5'd16 - {1'b0, k[3:0]}) : {1'b0, k[3:0]};
    case (i)
      5'd0:    off = 11'd0;
      5'd1:    off = 11'd196;
      5'd2:    off = 11'd390;
      5'd3:    off = 11'd581;
      5'd4:    off = 11'd765;
      5'd5:    off = 11'd943;
      5'd6:    off = 11'd1111;
      5'd7:    off = 11'd1269;
      5'd8:    off = 11'd1414;
      5'd9:    off = 11'd1546;
      5'd10:   off = 11'd1663;
      5'd11:   off = 11'd1764;
      5'd12:   off = 11'd1848;
      5'd13:   off = 11'd1914;
      5'd14:   off = 11'd1962;
      5'd15:   off = 11'd1990;
      default: off = 11'd2000;
    endcase
    return k[5] ? (12'd2048 - {1'b0, off}) : (12'd2048 + {1'b0, off});
  endfunction

  assign en_tx_byte = (state == SEND);
  assign ce_Fd      = (cb_Fd == FDW'(FD_DIV - 1));
  assign ce_bit     = en_tx_byte && ce_Fd && (cb_smp == SBW'(SMP_PER_BIT - 1));
  // T_end blocks a start in its own clk, even though the FSM is already idle
  assign accept     = st && !en_tx_byte && !T_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cb_Fd     <= '0;
      cb_smp    <= '0;
      phase     <= '0;
      sreg      <= '0;
`ifdef UTXD_PARITY_EN
      par       <= 1'b0;
`endif
      FSK_SH    <= 12'd2048;
      TXD       <= 1'b1;
      cb_tx_bit <= '0;
      T_end     <= 1'b0;
    end else begin
      T_end <= 1'b0;
      cb_Fd <= ce_Fd ? '0 : cb_Fd + FDW'(1);
      // phase runs freely across bit boundaries; tone follows TXD before this edge
      if (ce_Fd) begin
        FSK_SH <= sin_lut(phase[15:10]);
        phase  <= phase + (TXD ? 16'(MARK_INC) : 16'(SPACE_INC));
      end
      case (state)
        IDLE: if (accept) begin
          state     <= SEND;
          sreg      <= TX_dat;
`ifdef UTXD_PARITY_EN
          par       <= ^TX_dat;
`endif
          cb_tx_bit <= '0;
          TXD       <= 1'b0;
          cb_smp    <= '0;
          cb_Fd     <= '0;
        end
        default: if (ce_Fd) begin
          if (ce_bit) begin
            cb_smp <= '0;
            if (cb_tx_bit == LAST) begin
              state     <= IDLE;
              cb_tx_bit <= '0;
              TXD       <= 1'b1;
              T_end     <= 1'b1;
            end else begin
              cb_tx_bit <= cb_tx_bit + 4'd1;
              if (cb_tx_bit < 4'd8) begin
                TXD  <= sreg[0];
                sreg <= {1'b0, sreg[7:1]};
              end
`ifdef UTXD_PARITY_EN
              else if (cb_tx_bit == 4'd8) TXD <= par;
`endif
              else TXD <= 1'b1;
            end
          end else begin
            cb_smp <= cb_smp + SBW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_utxd_1byte.sv
// Bench for fsk_utxd_1byte: frame-bit scoreboard plus a DDS sample model.
module tb_fsk_utxd_1byte;

  localparam int FD  = 4;
  localparam int SPB = 8;
  localparam int MI  = 4096;
  localparam int SI  = 8192;
  localparam int BIT_CLKS = FD * SPB;
`ifdef UTXD_PARITY_EN
  localparam int NB = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int NB = 10;
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME_CLKS = NB * BIT_CLKS;

  logic        clk = 1'b0;
  logic        rst;
  logic        st;
  logic [7:0]  TX_dat;
  logic [11:0] FSK_SH;
  logic        TXD, en_tx_byte, ce_Fd, ce_bit, T_end;
  logic [3:0]  cb_tx_bit;

  fsk_utxd_1byte #(.FD_DIV(FD), .SMP_PER_BIT(SPB), .MARK_INC(MI), .SPACE_INC(SI)) dut (
    .clk(clk), .rst(rst), .st(st), .TX_dat(TX_dat), .FSK_SH(FSK_SH), .TXD(TXD),
    .en_tx_byte(en_tx_byte), .cb_tx_bit(cb_tx_bit), .ce_Fd(ce_Fd), .ce_bit(ce_bit),
    .T_end(T_end)
  );

  always #5 clk = ~clk;

  typedef struct { logic b; int idx; } exp_t;
  typedef struct { logic [7:0] dat; logic par; } vec_t;

  exp_t  exp_q[$];
  vec_t  vecs[5];
  int    checks = 0;
  int    fails  = 0;

  // monitor state
  int          ncyc = 0;
  int          start_cyc = 0;
  bit          frame_on = 1'b0;
  bit          prv_en = 1'b0;
  logic [3:0]  prv_cb = '0;
  logic [15:0] phase = '0;
  bit          sh_pend = 1'b0;
  int          sh_exp = 0;

  function automatic int sin_ref(input int k);
    return int'(2048.0 + 2000.0 * $sin(2.0 * 3.14159265358979 * k / 64.0));
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input logic p);
    exp_t e;
    for (int i = 0; i < NB; i++) begin
      e.idx = i;
      if (i == 0)                 e.b = 1'b0;
      else if (i <= 8)            e.b = d[i-1];
      else if (PAR && i == 9)     e.b = p;
      else                        e.b = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (sh_pend) begin
        chk("fsk_sample", int'(FSK_SH), sh_exp);
        sh_pend = 1'b0;
      end
      if (en_tx_byte && (!prv_en || cb_tx_bit != prv_cb)) begin
        if (!prv_en) begin
          start_cyc = ncyc;
          frame_on  = 1'b1;
        end
        if (exp_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL bit_unexpected got=cb%0d exp=none", cb_tx_bit);
        end else begin
          e = exp_q.pop_front();
          chk("txd_bit", int'(TXD), int'(e.b));
          chk("cb_tx_bit", int'(cb_tx_bit), e.idx);
          chk("bit_time", ncyc - start_cyc, e.idx * BIT_CLKS);
        end
      end
      if (ce_bit) chk("ce_bit_time", frame_on ? (ncyc - start_cyc + 1) % BIT_CLKS : -1, 0);
      if (T_end) begin
        chk("t_end_time", frame_on ? ncyc - start_cyc : -1, FRAME_CLKS);
        chk("t_end_bits_left", exp_q.size(), 0);
        frame_on = 1'b0;
      end
      prv_en = en_tx_byte;
      prv_cb = cb_tx_bit;
      if (rst) begin
        phase = '0; sh_pend = 1'b0; frame_on = 1'b0;
        exp_q.delete();
      end else if (ce_Fd) begin
        sh_exp  = sin_ref(int'(phase[15:10]));
        phase   = phase + (TXD ? 16'(MI) : 16'(SI));
        sh_pend = 1'b1;
      end
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin @(negedge clk); k++; end while ((en_tx_byte || T_end) && k < 800);
    chk("idle_timeout", int'(en_tx_byte), 0);
  endtask

  task automatic wait_tend();
    int k = 0;
    do begin @(negedge clk); k++; end while (!T_end && k < 800);
    chk("t_end_timeout", int'(T_end), 1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p);
    wait_idle();
    @(posedge clk); #1;
    st = 1'b1; TX_dat = d;
    push_frame(d, p);
    @(posedge clk); #1;
    st = 1'b0; TX_dat = 8'hxx;
  endtask

  initial begin
    int k;
    int idle_exp[5];
    int tcnt;
    rst = 1'b1; st = 1'b0; TX_dat = 8'h00;
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h01, 1'b1};
    idle_exp = '{2048, 2813, 3462, 3896, 4048};
    fork monitor(); join_none

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fsk_sh", int'(FSK_SH), 2048);
    chk("rst_txd", int'(TXD), 1);
    chk("rst_en", int'(en_tx_byte), 0);
    chk("rst_cb_tx_bit", int'(cb_tx_bit), 0);
    chk("rst_t_end", int'(T_end), 0);
    chk("rst_ce_fd", int'(ce_Fd), 0);
    chk("rst_ce_bit", int'(ce_bit), 0);
    @(posedge clk); #1 rst = 1'b0;

    // first ce_Fd is the 4th clk after release
    @(negedge clk);
    k = 1;
    while (!ce_Fd && k < 20) begin @(negedge clk); k++; end
    chk("first_ce_fd_clk", k, 4);

    // idle mark tone walks the table in steps of 4
    for (int i = 0; i < 5; i++) begin
      k = 0;
      while (!ce_Fd && k < 20) begin @(negedge clk); k++; end
      @(negedge clk);
      chk("idle_tone", int'(FSK_SH), idle_exp[i]);
    end

    // table-driven frames
    foreach (vecs[i]) begin
      send_frame(vecs[i].dat, vecs[i].par);
      wait_tend();
    end

    // st held through a frame and on the T_end clk is ignored; one clk later it starts
    wait_idle();
    @(posedge clk); #1;
    st = 1'b1; TX_dat = 8'hA5;
    push_frame(8'hA5, 1'b0);
    @(posedge clk); #1 TX_dat = 8'h3C;
    wait_tend();
    @(negedge clk);
    chk("st_on_t_end_ignored", int'(en_tx_byte), 0);
    push_frame(8'h3C, 1'b0);
    @(negedge clk);
    chk("b2b_en", int'(en_tx_byte), 1);
    chk("b2b_txd_start", int'(TXD), 0);
    st = 1'b0;
    wait_tend();

    // reset mid-frame aborts without T_end
    send_frame(8'h5A, 1'b0);
    k = 0;
    do begin @(negedge clk); k++; end while (cb_tx_bit != 4'd4 && k < 400);
    chk("reach_bit4", int'(cb_tx_bit), 4);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_en", int'(en_tx_byte), 0);
    chk("abort_txd", int'(TXD), 1);
    chk("abort_cb_tx_bit", int'(cb_tx_bit), 0);
    chk("abort_fsk_sh", int'(FSK_SH), 2048);
    tcnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (T_end) tcnt++;
    end
    chk("abort_no_t_end", tcnt, 0);
    send_frame(8'hC3, 1'b0);
    wait_tend();

    repeat (4) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
